idli_sqi_ctrl_m: RTL and testbench
==================================

# idli_sqi_ctrl_m

Sequencer and arbiter for one SQI serial SRAM (23LC1024-style, quad mode) shared between the instruction-fetch port and the load/store port of the core. The block grants one requester at a time and serialises a full command/address/dummy/data transaction as 4-bit nibbles with a generated SCK. It returns a 16-bit read word or commits a 16-bit write. One instance drives each memory chip (lo and hi).

## Interface
- `ADDR_W`, 16: word-address width. The byte address on the wire is 24 bits: `{7'b0, addr, 1'b0}`.
- `DATA_W`, 16: word width. Always 4 nibbles; no other value is supported.
- `i_gck`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_fetch_req`  in  1  fetch read request; held until granted.
- `i_fetch_addr`  in  ADDR_W  fetch word address.
- `o_fetch_gnt`  out  1  fetch request accepted this cycle.
- `o_fetch_rvalid`  out  1  one-cycle pulse; `o_rdata` holds fetch data.
- `i_data_req`  in  1  load/store request; held until granted.
- `i_data_we`  in  1  1 = write, 0 = read.
- `i_data_addr`  in  ADDR_W  load/store word address.
- `i_data_wdata`  in  DATA_W  store data.
- `o_data_gnt`  out  1  load/store request accepted this cycle.
- `o_data_rvalid`  out  1  one-cycle pulse; `o_rdata` holds load data.
- `o_rdata`  out  DATA_W  read word, shared by both ports.
- `o_mem_sck`  out  1  SQI clock.
- `o_mem_cs`  out  1  chip select, active-low.
- `o_mem_sio`  out  4  nibble driven to the memory.
- `o_mem_oe`  out  1  1 = controller drives SIO.
- `i_mem_sio`  in  4  nibble from the memory.

## Operation
- The FSM has six states: IDLE, CMD, ADDR, DUMMY, DATA, DONE.
- **Nibble timing.** Each nibble takes 2 cycles: phase 0 has `sck=0` with `o_mem_sio` updated; phase 1 has `sck=1`. A 1-bit phase flop and a 3-bit nibble counter, cleared on every state change, track position.
- **IDLE.**
  - `cs=1`, `sck=0`, `oe=0`.
  - If any request is present, grant exactly one requester combinationally that cycle.
  - On the grant, capture `addr`, `we` (fetch forces 0), `wdata` and the requester id. Move to CMD.
- **CMD**, 2 nibbles: 0x03 for read, 0x02 for write, high nibble first, `oe=1`.
- **ADDR**, 6 nibbles: the 24-bit byte address, MSB nibble first, `oe=1`.
- **DUMMY**, 2 nibbles, reads only: `oe=0`, SIO ignored. Writes skip from ADDR to DATA.
- **DATA**, 4 nibbles, MSB nibble first.
  - Write: drive `wdata[15:12]`, `[11:8]`, `[7:4]`, `[3:0]` with `oe=1`.
  - Read: `oe=0`; sample `i_mem_sio` on the gck edge ending phase 1 and shift it into the read register.
- **DONE**, 1 cycle: `cs=1`, `sck=0`, `oe=0`.
  - For reads, pulse the `rvalid` of the captured requester, with `o_rdata` valid that cycle.
  - Return to IDLE. No grant is given in DONE.
- **Arbitration.** Two-way round-robin.
  - A `last_q` bit records the most recent grantee.
  - A lone requester always wins.
  - On simultaneous requests, the port not granted last wins.
  - Reset sets `last_q` to data, so fetch wins the first tie.
- **`o_rdata`.** Holds its last value outside rvalid. Reset value 0.
- **Requests during a transaction.** These are ignored until IDLE. No grant is ever given outside IDLE, and at most one grant is given per cycle.

## Timing
- Output reset values: `o_mem_cs=1`, `o_mem_sck=0`, `o_mem_oe=0`, `o_mem_sio=0`, both gnt 0, both rvalid 0, `o_rdata=0`, state IDLE.
- Reset mid-transaction is asynchronous. CS rises immediately, SCK and OE go low, the transaction is dropped and no rvalid is issued.
- With the grant in cycle 0:
  - CS is low in cycles 1–28 for a read, or 1–24 for a write.
  - DONE is cycle 29 for a read (rvalid here) or 25 for a write.
  - The earliest next grant is cycle 30 for a read or 26 for a write.
- `o_mem_sio` and `o_mem_oe` are registered and change only at phase-0 entry. SCK is registered.
- The first read nibble is sampled at the end of cycle 22; the last at the end of cycle 28.
- `o_fetch_gnt`/`o_data_gnt` depend combinationally on the request inputs in IDLE only. All other outputs are flop-driven.

## Test plan
- **Fetch read.** Fetch read of 0x1234 with the memory model returning 0xBEEF.
  - Wire sequence: nibbles 0,3, then 0,0,2,4,6,8.
  - `oe` drops for cycles 17–28.
  - `o_fetch_rvalid=1` and `o_rdata=0xBEEF` in cycle 29; `o_data_rvalid` stays 0.
- **Data write.** Data write of 0xA5C3 to 0x0001.
  - Wire sequence: nibbles 0,2, then 0,0,0,0,0,2, then A,5,C,3.
  - `oe=1` throughout cycles 1–24; CS rises in cycle 25; no rvalid.
  - The memory model holds 0xA5C3 at byte 0x000002.
- **Tie after reset.** Both ports request together after reset.
  - Fetch is granted in cycle 0 and data in cycle 30.
  - If both then re-request, fetch is granted next. Grants strictly alternate.
- **Lone requester.** Data requests alone three times back-to-back.
  - It is granted every time, at cycles 0, 30 and 60 for reads.
- **Reset mid-transaction.** `rst_n` is asserted in cycle 10 of a read.
  - `cs=1`, `sck=0`, `oe=0` immediately.
  - After release, no rvalid appears, and a fresh fetch request is granted in the first IDLE cycle.
- **No requests.** With no requests for 100 cycles, `cs` stays 1, `sck` stays 0, and no gnt or rvalid is asserted.

Source files
------------

// File: rtl/idli_sqi_ctrl_m.sv
// Quad-SPI (SQI) serial SRAM sequencer with a two-port round-robin arbiter.
// Runs one command/address/dummy/data transaction at a time on a 23LC1024-style chip.
module idli_sqi_ctrl_m #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              i_gck,
  input  logic              rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_rvalid,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_gnt,
  output logic              o_data_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_sck,
  output logic              o_mem_cs,
  output logic [3:0]        o_mem_sio,
  output logic              o_mem_oe,
  input  logic [3:0]        i_mem_sio
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              id;      // 1 = load/store port, 0 = fetch port
  } req_t;

  state_t              state_q;
  logic                phase_q;
  logic [2:0]          cnt_q;
  logic                last_q;  // most recent grantee, same encoding as req_t.id
  req_t                req_q;
  req_t                req_d;
  logic [DATA_W-5:0]   shift_q;
  state_t              nxt_state;
  logic [2:0]          nxt_cnt;
  logic                idle;

  // Lone requester always wins; on a tie the port not served last wins.
  assign idle        = (state_q == S_IDLE);
  assign o_fetch_gnt = idle & i_fetch_req & (~i_data_req | last_q);
  assign o_data_gnt  = idle & i_data_req  & (~i_fetch_req | ~last_q);

  always_comb begin
    req_d.addr  = o_data_gnt ? i_data_addr : i_fetch_addr;
    req_d.we    = o_data_gnt & i_data_we;
    req_d.wdata = i_data_wdata;
    req_d.id    = o_data_gnt;
  end

  // Position of the next nibble once the current one finishes its phase 1.
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q + 3'd1;
    case (state_q)
      S_CMD:   if (cnt_q == 3'd1) begin nxt_state = S_ADDR; nxt_cnt = 3'd0; end
      S_ADDR:  if (cnt_q == 3'd5) begin
                 nxt_state = req_q.we ? S_DATA : S_DUMMY;
                 nxt_cnt   = 3'd0;
               end
      S_DUMMY: if (cnt_q == 3'd1) begin nxt_state = S_DATA; nxt_cnt = 3'd0; end
      S_DATA:  if (cnt_q == 3'd3) begin nxt_state = S_DONE; nxt_cnt = 3'd0; end
      default: begin nxt_state = S_IDLE; nxt_cnt = 3'd0; end
    endcase
  end

  function automatic logic [3:0] nib_of(state_t st, logic [2:0] c, req_t r);
    logic [23:0] baddr;
    logic [7:0]  cmd;
    logic [3:0]  nib;
    baddr            = '0;
    baddr[ADDR_W:1]  = r.addr;
    cmd              = r.we ? 8'h02 : 8'h03;
    nib              = 4'h0;
    case (st)
      S_CMD:   nib = c[0] ? cmd[3:0] : cmd[7:4];
      S_ADDR:  nib = baddr[{(3'd5 - c), 2'b00} +: 4];
      S_DATA:  nib = r.we ? r.wdata[{(2'd3 - c[1:0]), 2'b00} +: 4] : 4'h0;
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  function automatic logic oe_of(state_t st, logic we);
    return (st == S_CMD) || (st == S_ADDR) || ((st == S_DATA) && we);
  endfunction

  always_ff @(posedge i_gck or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      phase_q        <= 1'b0;
      cnt_q          <= 3'd0;
      last_q         <= 1'b1;
      req_q          <= '0;
      shift_q        <= '0;
      o_rdata        <= '0;
      o_fetch_rvalid <= 1'b0;
      o_data_rvalid  <= 1'b0;
      o_mem_cs       <= 1'b1;
      o_mem_sck      <= 1'b0;
      o_mem_oe       <= 1'b0;
      o_mem_sio      <= 4'h0;
    end else begin
      o_fetch_rvalid <= 1'b0;
      o_data_rvalid  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (o_fetch_gnt | o_data_gnt) begin
            req_q     <= req_d;
            last_q    <= o_data_gnt;
            state_q   <= S_CMD;
            phase_q   <= 1'b0;
            cnt_q     <= 3'd0;
            o_mem_cs  <= 1'b0;
            o_mem_sck <= 1'b0;
            o_mem_oe  <= 1'b1;
            o_mem_sio <= nib_of(S_CMD, 3'd0, req_d);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          if (!phase_q) begin
            phase_q   <= 1'b1;
            o_mem_sck <= 1'b1;
          end else begin
            phase_q   <= 1'b0;
            o_mem_sck <= 1'b0;
            state_q   <= nxt_state;
            cnt_q     <= nxt_cnt;
            // Memory drives during sck high; capture on the edge that ends it.
            if (state_q == S_DATA && !req_q.we)
              shift_q <= {shift_q[DATA_W-9:0], i_mem_sio};
            if (nxt_state == S_DONE) begin
              o_mem_cs  <= 1'b1;
              o_mem_oe  <= 1'b0;
              o_mem_sio <= 4'h0;
              if (!req_q.we) begin
                o_rdata        <= {shift_q, i_mem_sio};
                o_fetch_rvalid <= ~req_q.id;
                o_data_rvalid  <= req_q.id;
              end
            end else begin
              o_mem_oe  <= oe_of(nxt_state, req_q.we);
              o_mem_sio <= nib_of(nxt_state, nxt_cnt, req_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Directed bench for idli_sqi_ctrl_m with a behavioural SQI SRAM model on the wire.
module tb_idli_sqi_ctrl_m;
  logic        i_gck = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fetch_req = 1'b0;
  logic [15:0] i_fetch_addr = 16'h0;
  logic        o_fetch_gnt, o_fetch_rvalid;
  logic        i_data_req = 1'b0;
  logic        i_data_we = 1'b0;
  logic [15:0] i_data_addr = 16'h0;
  logic [15:0] i_data_wdata = 16'h0;
  logic        o_data_gnt, o_data_rvalid;
  logic [15:0] o_rdata;
  logic        o_mem_sck, o_mem_cs, o_mem_oe;
  logic [3:0]  o_mem_sio;
  logic [3:0]  i_mem_sio = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;

  idli_sqi_ctrl_m #(.ADDR_W(16), .DATA_W(16)) dut (
    .i_gck(i_gck), .rst_n(rst_n),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_fetch_gnt(o_fetch_gnt), .o_fetch_rvalid(o_fetch_rvalid),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .o_data_gnt(o_data_gnt), .o_data_rvalid(o_data_rvalid),
    .o_rdata(o_rdata), .o_mem_sck(o_mem_sck), .o_mem_cs(o_mem_cs),
    .o_mem_sio(o_mem_sio), .o_mem_oe(o_mem_oe), .i_mem_sio(i_mem_sio)
  );

  always #5 i_gck = ~i_gck;

  // SRAM model: logs every nibble seen on an sck rising edge, serves reads, commits writes.
  logic [3:0]  m_log [16];
  int          m_cnt = 0;
  logic        m_pcs = 1'b1;
  logic        m_psck = 1'b0;
  logic [15:0] mem [int];

  always @(negedge i_gck) begin
    logic [23:0] ba;
    logic [15:0] w;
    ba = {m_log[2], m_log[3], m_log[4], m_log[5], m_log[6], m_log[7]};
    if (!o_mem_cs && m_pcs) m_cnt = 0;
    if (!o_mem_cs && o_mem_sck && !m_psck) begin
      if (m_cnt < 16) m_log[m_cnt] = o_mem_sio;
      m_cnt++;
    end else if (!o_mem_cs && !o_mem_sck && m_cnt >= 10 && m_cnt < 14 && m_log[1] == 4'h3) begin
      w = mem.exists(int'(ba)) ? mem[int'(ba)] : 16'h0;
      w = w << (4 * (m_cnt - 10));
      i_mem_sio = w[15:12];
    end
    if (o_mem_cs && !m_pcs && m_cnt == 12 && m_log[1] == 4'h2)
      mem[int'(ba)] = {m_log[8], m_log[9], m_log[10], m_log[11]};
    m_pcs  = o_mem_cs;
    m_psck = o_mem_sck;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge i_gck);
    n_tests++; if (o_mem_cs !== 1'b1)   begin n_fail++; $display("FAIL rst_cs got %b exp 1", o_mem_cs); end
    n_tests++; if (o_mem_sck !== 1'b0)  begin n_fail++; $display("FAIL rst_sck got %b exp 0", o_mem_sck); end
    n_tests++; if (o_mem_oe !== 1'b0)   begin n_fail++; $display("FAIL rst_oe got %b exp 0", o_mem_oe); end
    n_tests++; if (o_mem_sio !== 4'h0)  begin n_fail++; $display("FAIL rst_sio got %h exp 0", o_mem_sio); end
    n_tests++; if (o_rdata !== 16'h0)   begin n_fail++; $display("FAIL rst_rdata got %h exp 0", o_rdata); end
    n_tests++; if ({o_fetch_gnt, o_data_gnt, o_fetch_rvalid, o_data_rvalid} !== 4'b0)
      begin n_fail++; $display("FAIL rst_hs got %b exp 0000", {o_fetch_gnt, o_data_gnt, o_fetch_rvalid, o_data_rvalid}); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge i_gck);
      n_tests++; if (o_mem_cs !== 1'b1 || o_mem_sck !== 1'b0)
        begin n_fail++; $display("FAIL idle_bus c=%0d got cs=%b sck=%b exp cs=1 sck=0", c, o_mem_cs, o_mem_sck); end
      n_tests++; if ({o_fetch_gnt, o_data_gnt, o_fetch_rvalid, o_data_rvalid} !== 4'b0)
        begin n_fail++; $display("FAIL idle_hs c=%0d got %b exp 0000", c, {o_fetch_gnt, o_data_gnt, o_fetch_rvalid, o_data_rvalid}); end
    end
  endtask

  task automatic test_fetch_read();
    logic [3:0] exp_n [8];
    exp_n = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    mem[32'h2468] = 16'hBEEF;
    @(posedge i_gck); #1;
    i_fetch_req = 1'b1; i_fetch_addr = 16'h1234;
    for (int c = 0; c <= 30; c++) begin
      if (c == 1) i_fetch_req = 1'b0;
      @(negedge i_gck);
      if (c == 0) begin
        n_tests++; if (o_fetch_gnt !== 1'b1 || o_data_gnt !== 1'b0)
          begin n_fail++; $display("FAIL fr_gnt got f=%b d=%b exp f=1 d=0", o_fetch_gnt, o_data_gnt); end
      end else if (c <= 28) begin
        n_tests++; if (o_mem_cs !== 1'b0) begin n_fail++; $display("FAIL fr_cs c=%0d got %b exp 0", c, o_mem_cs); end
        n_tests++; if (o_mem_sck !== (c % 2 == 0)) begin n_fail++; $display("FAIL fr_sck c=%0d got %b exp %b", c, o_mem_sck, (c % 2 == 0)); end
        n_tests++; if (o_mem_oe !== (c <= 16)) begin n_fail++; $display("FAIL fr_oe c=%0d got %b exp %b", c, o_mem_oe, (c <= 16)); end
      end
      n_tests++; if (o_fetch_rvalid !== (c == 29)) begin n_fail++; $display("FAIL fr_rvalid c=%0d got %b exp %b", c, o_fetch_rvalid, (c == 29)); end
      n_tests++; if (o_data_rvalid !== 1'b0) begin n_fail++; $display("FAIL fr_drvalid c=%0d got %b exp 0", c, o_data_rvalid); end
      if (c >= 29) begin
        n_tests++; if (o_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL fr_rdata c=%0d got %h exp beef", c, o_rdata); end
        n_tests++; if (o_mem_cs !== 1'b1 || o_mem_oe !== 1'b0) begin n_fail++; $display("FAIL fr_done c=%0d got cs=%b oe=%b exp cs=1 oe=0", c, o_mem_cs, o_mem_oe); end
      end
      @(posedge i_gck); #1;
    end
    n_tests++; if (m_cnt !== 14) begin n_fail++; $display("FAIL fr_nibcnt got %0d exp 14", m_cnt); end
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (m_log[i] !== exp_n[i]) begin n_fail++; $display("FAIL fr_wire n=%0d got %h exp %h", i, m_log[i], exp_n[i]); end
    end
  endtask

  task automatic test_data_write();
    logic [3:0] exp_n [12];
    exp_n = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'hA, 4'h5, 4'hC, 4'h3};
    @(posedge i_gck); #1;
    i_data_req = 1'b1; i_data_we = 1'b1; i_data_addr = 16'h0001; i_data_wdata = 16'hA5C3;
    for (int c = 0; c <= 56; c++) begin
      if (c == 1) begin i_data_req = 1'b0; i_data_we = 1'b0; end
      if (c == 25) begin i_fetch_req = 1'b1; i_fetch_addr = 16'h0001; end
      if (c == 27) i_fetch_req = 1'b0;
      @(negedge i_gck);
      if (c == 0) begin
        n_tests++; if (o_data_gnt !== 1'b1 || o_fetch_gnt !== 1'b0)
          begin n_fail++; $display("FAIL dw_gnt got d=%b f=%b exp d=1 f=0", o_data_gnt, o_fetch_gnt); end
      end else if (c <= 24) begin
        n_tests++; if (o_mem_cs !== 1'b0 || o_mem_oe !== 1'b1)
          begin n_fail++; $display("FAIL dw_bus c=%0d got cs=%b oe=%b exp cs=0 oe=1", c, o_mem_cs, o_mem_oe); end
      end else if (c == 25) begin
        n_tests++; if (o_mem_cs !== 1'b1 || o_mem_oe !== 1'b0)
          begin n_fail++; $display("FAIL dw_done got cs=%b oe=%b exp cs=1 oe=0", o_mem_cs, o_mem_oe); end
        n_tests++; if (o_fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL dw_gnt_in_done got %b exp 0", o_fetch_gnt); end
      end else if (c == 26) begin
        n_tests++; if (o_fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL dw_next_gnt got %b exp 1", o_fetch_gnt); end
        n_tests++; if (m_cnt !== 12) begin n_fail++; $display("FAIL dw_nibcnt got %0d exp 12", m_cnt); end
        for (int i = 0; i < 12; i++) begin
          n_tests++; if (m_log[i] !== exp_n[i]) begin n_fail++; $display("FAIL dw_wire n=%0d got %h exp %h", i, m_log[i], exp_n[i]); end
        end
        n_tests++; if (!mem.exists(2) || mem[2] !== 16'hA5C3)
          begin n_fail++; $display("FAIL dw_mem got %h exp a5c3", mem.exists(2) ? mem[2] : 16'hxxxx); end
      end
      if (c <= 26) begin
        n_tests++; if (o_fetch_rvalid !== 1'b0 || o_data_rvalid !== 1'b0)
          begin n_fail++; $display("FAIL dw_rvalid c=%0d got f=%b d=%b exp 0", c, o_fetch_rvalid, o_data_rvalid); end
      end
      if (c == 55) begin
        n_tests++; if (o_fetch_rvalid !== 1'b1 || o_rdata !== 16'hA5C3)
          begin n_fail++; $display("FAIL dw_readback got rv=%b rdata=%h exp rv=1 rdata=a5c3", o_fetch_rvalid, o_rdata); end
      end
      @(posedge i_gck); #1;
    end
  endtask

  task automatic test_tie();
    rst_n = 1'b0;
    @(negedge i_gck);
    rst_n = 1'b1;
    n_tests++; if (o_rdata !== 16'h0) begin n_fail++; $display("FAIL tie_rst_rdata got %h exp 0", o_rdata); end
    @(posedge i_gck); #1;
    i_fetch_req = 1'b1; i_fetch_addr = 16'h0020;
    i_data_req  = 1'b1; i_data_we = 1'b0; i_data_addr = 16'h0010;
    for (int c = 0; c <= 91; c++) begin
      @(negedge i_gck);
      n_tests++; if (o_fetch_gnt !== (c == 0 || c == 60))
        begin n_fail++; $display("FAIL tie_fgnt c=%0d got %b exp %b", c, o_fetch_gnt, (c == 0 || c == 60)); end
      n_tests++; if (o_data_gnt !== (c == 30 || c == 90))
        begin n_fail++; $display("FAIL tie_dgnt c=%0d got %b exp %b", c, o_data_gnt, (c == 30 || c == 90)); end
      n_tests++; if (o_fetch_rvalid !== (c == 29 || c == 89) || o_data_rvalid !== (c == 59))
        begin n_fail++; $display("FAIL tie_rvalid c=%0d got f=%b d=%b", c, o_fetch_rvalid, o_data_rvalid); end
      @(posedge i_gck); #1;
    end
    i_fetch_req = 1'b0; i_data_req = 1'b0;
    repeat (32) @(posedge i_gck);
    #1;
  endtask

  task automatic test_lone();
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_addr = 16'h0100;
    for (int c = 0; c <= 60; c++) begin
      @(negedge i_gck);
      n_tests++; if (o_data_gnt !== (c % 30 == 0) || o_fetch_gnt !== 1'b0)
        begin n_fail++; $display("FAIL lone_gnt c=%0d got d=%b f=%b exp d=%b f=0", c, o_data_gnt, o_fetch_gnt, (c % 30 == 0)); end
      n_tests++; if (o_data_rvalid !== (c == 29 || c == 59))
        begin n_fail++; $display("FAIL lone_rvalid c=%0d got %b exp %b", c, o_data_rvalid, (c == 29 || c == 59)); end
      @(posedge i_gck); #1;
    end
    i_data_req = 1'b0;
    repeat (31) @(posedge i_gck);
    #1;
  endtask

  task automatic test_reset_mid();
    i_fetch_req = 1'b1; i_fetch_addr = 16'h1234;
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) i_fetch_req = 1'b0;
      @(negedge i_gck);
      if (c == 0) begin
        n_tests++; if (o_fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt got %b exp 1", o_fetch_gnt); end
      end
      if (c < 10) begin @(posedge i_gck); #1; end
    end
    n_tests++; if (o_mem_cs !== 1'b0) begin n_fail++; $display("FAIL rm_active got cs=%b exp 0", o_mem_cs); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (o_mem_cs !== 1'b1 || o_mem_sck !== 1'b0 || o_mem_oe !== 1'b0)
      begin n_fail++; $display("FAIL rm_async got cs=%b sck=%b oe=%b exp 1 0 0", o_mem_cs, o_mem_sck, o_mem_oe); end
    @(posedge i_gck); #1;
    rst_n = 1'b1;
    i_fetch_req = 1'b1; i_fetch_addr = 16'h1234;
    for (int c = 0; c <= 30; c++) begin
      if (c == 1) i_fetch_req = 1'b0;
      @(negedge i_gck);
      n_tests++; if (o_fetch_gnt !== (c == 0)) begin n_fail++; $display("FAIL rm_regnt c=%0d got %b exp %b", c, o_fetch_gnt, (c == 0)); end
      n_tests++; if (o_fetch_rvalid !== (c == 29) || o_data_rvalid !== 1'b0)
        begin n_fail++; $display("FAIL rm_rvalid c=%0d got f=%b d=%b exp f=%b d=0", c, o_fetch_rvalid, o_data_rvalid, (c == 29)); end
      @(posedge i_gck); #1;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fetch_read();
    test_data_write();
    test_tie();
    test_lone();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
